// File: rtl/ifu_align_buf_pkg.sv
// Shared types and helpers for the IFU fetch-line buffer and RVC aligner.
package ifu_align_buf_pkg;

    localparam logic [31:0] Nop = 32'h0000_0013;
    localparam int unsigned FetchLineWidth = 64;

    typedef struct packed {
        logic [FetchLineWidth-1:0] data;
        logic [30:0]               pc;
        logic                      err;
    } fetch_line_t;

    function automatic logic is_comp(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

    // 48-bit and wider encodings share the 11111 low-bit pattern.
    function automatic logic is_oversize(input logic [15:0] parcel);
        return (parcel[1:0] == 2'b11) && (parcel[4:2] == 3'b111);
    endfunction

endpackage

// File: rtl/ifu_align_buf_if.sv
// Fetch-line, redirect and decode-side signals of the aligner.
interface ifu_align_buf_if #(
    parameter int unsigned LineWidth = 64
);
    logic                 flush_f;
    logic [30:0]          flush_pc;
    logic                 line_valid;
    logic                 line_ready;
    logic [LineWidth-1:0] line_data;
    logic [30:0]          line_pc;
    logic                 line_err;
    logic                 instr_valid_d0;
    logic                 instr_ready_d0;
    logic [31:0]          instr_d0;
    logic [30:0]          pc_d0;
    logic                 comp_d0;
    logic                 fault_d0;
    logic                 illegal_d0;

    modport master (
        output flush_f, flush_pc, line_valid, line_data, line_pc, line_err, instr_ready_d0,
        input  line_ready, instr_valid_d0, instr_d0, pc_d0, comp_d0, fault_d0, illegal_d0
    );

    modport slave (
        input  flush_f, flush_pc, line_valid, line_data, line_pc, line_err, instr_ready_d0,
        output line_ready, instr_valid_d0, instr_d0, pc_d0, comp_d0, fault_d0, illegal_d0
    );
endinterface

// File: rtl/ifu_align_buf_line_fifo.sv
// Circular line FIFO exposing the head entry and the one behind it.
module ifu_line_fifo #(
    parameter int unsigned W     = 65,
    parameter int unsigned Depth = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [W-1:0] next_data,
    output logic         next_vld,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [AW-1:0] next_idx;
    logic          do_push, do_pop;
    logic [W-1:0]  mem_q [Depth];

    // Extra pointer MSB tells a full ring from an empty one after wrap.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(Depth));
    assign next_vld = (count > (AW+1)'(1));
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign next_idx = rd_ptr_q[AW-1:0] + 1'b1;

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign next_data = mem_q[next_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ifu_align_buf.sv
// Buffers fetch lines and extracts 16/32-bit instructions in program order,
// including 32-bit instructions straddling two lines.
module ifu_align_buf
    import ifu_align_buf_pkg::*;
#(
    parameter int unsigned LineWidth = 64,
    parameter int unsigned Depth     = 2,
    parameter logic [30:0] ResetPc   = 31'h0
) (
    input logic             clk,
    input logic             rst,
    ifu_align_buf_if.slave  bus
);
    localparam int unsigned P  = LineWidth / 16;
    localparam int unsigned PW = $clog2(P);
    localparam int unsigned LW = 31 - PW;

    logic [LW-1:0]      exp_line_q, exp_line_d, head_line_q, head_line_d;
    logic [PW-1:0]      ptr_q, ptr_d, ptr_inc;
    logic               vld_q, vld_d, comp_q, comp_d, fault_q, fault_d, illegal_q, illegal_d;
    logic [31:0]        instr_q, instr_d;
    logic [30:0]        pc_q, pc_d;

    logic [LineWidth:0] head_ent, next_ent;
    logic [LineWidth-1:0] head_data;
    logic               head_err, next_err, next_vld, full, empty;
    logic               push, pop, take, comp, last, complete;
    logic [15:0]        lo, hi;
    logic [PW:0]        adv;
    logic               unused_line_pc_lo;

    ifu_line_fifo #(.W(LineWidth + 1), .Depth(Depth)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush_f),
        .push      (push),
        .push_data ({bus.line_err, bus.line_data}),
        .pop       (pop),
        .head_data (head_ent),
        .next_data (next_ent),
        .next_vld  (next_vld),
        .full      (full),
        .empty     (empty)
    );

    assign unused_line_pc_lo = ^bus.line_pc[PW-1:0];
    assign head_data = head_ent[LineWidth-1:0];
    assign head_err  = head_ent[LineWidth];
    assign next_err  = next_ent[LineWidth];

    // Stale lines still handshake so the memory side never stalls on them.
    assign bus.line_ready = !full;
    assign push = bus.line_valid && !full && !bus.flush_f
                  && (bus.line_pc[30:PW] == exp_line_q);

    assign ptr_inc  = ptr_q + 1'b1;
    assign last     = (ptr_q == PW'(P - 1));
    assign lo       = head_data[{ptr_q, 4'b0000} +: 16];
    assign hi       = last ? next_ent[15:0] : head_data[{ptr_inc, 4'b0000} +: 16];
    assign comp     = is_comp(lo);
    assign complete = !empty && (comp || !last || next_vld);
    assign take     = complete && (!vld_q || bus.instr_ready_d0) && !bus.flush_f;
    assign adv      = {1'b0, ptr_q} + (PW+1)'(comp ? 1 : 2);
    assign pop      = take && adv[PW];

    always_comb begin
        exp_line_d  = exp_line_q;
        head_line_d = head_line_q;
        ptr_d       = ptr_q;
        if (bus.flush_f) begin
            exp_line_d  = bus.flush_pc[30:PW];
            head_line_d = bus.flush_pc[30:PW];
            ptr_d       = bus.flush_pc[PW-1:0];
        end else begin
            if (push) exp_line_d  = exp_line_q + 1'b1;
            if (take) ptr_d       = adv[PW-1:0];
            if (pop)  head_line_d = head_line_q + 1'b1;
        end
    end

    always_comb begin
        vld_d     = vld_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        comp_d    = comp_q;
        fault_d   = fault_q;
        illegal_d = illegal_q;
        if (bus.flush_f) begin
            vld_d = 1'b0;
        end else if (take) begin
            vld_d     = 1'b1;
            instr_d   = comp ? {16'h0000, lo} : {hi, lo};
            pc_d      = {head_line_q, ptr_q};
            comp_d    = comp;
            fault_d   = head_err || (!comp && last && next_err);
            illegal_d = is_oversize(lo);
        end else if (bus.instr_ready_d0) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_line_q  <= ResetPc[30:PW];
            head_line_q <= ResetPc[30:PW];
            ptr_q       <= ResetPc[PW-1:0];
            vld_q       <= 1'b0;
            instr_q     <= Nop;
            pc_q        <= '0;
            comp_q      <= 1'b0;
            fault_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            exp_line_q  <= exp_line_d;
            head_line_q <= head_line_d;
            ptr_q       <= ptr_d;
            vld_q       <= vld_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            comp_q      <= comp_d;
            fault_q     <= fault_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.instr_valid_d0 = vld_q;
    assign bus.instr_d0       = instr_q;
    assign bus.pc_d0          = pc_q;
    assign bus.comp_d0        = comp_q;
    assign bus.fault_d0       = fault_q;
    assign bus.illegal_d0     = illegal_q;

endmodule

// File: tb/tb_ifu_align_buf.sv
// Directed bench for ifu_align_buf with LineWidth=64, Depth=2, ResetPc=0.
module tb_ifu_align_buf;
    import ifu_align_buf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    ifu_align_buf_if #(.LineWidth(64)) bus ();

    ifu_align_buf #(.LineWidth(64), .Depth(2), .ResetPc(31'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; a line offered across an edge with line_ready high is retired.
    task automatic tick();
        logic acc;
        acc = bus.line_valid && bus.line_ready;
        @(posedge clk);
        #1;
        if (acc) bus.line_valid = 1'b0;
    endtask

    task automatic offer(input fetch_line_t l);
        bus.line_valid = 1'b1;
        bus.line_data  = l.data;
        bus.line_pc    = l.pc;
        bus.line_err   = l.err;
        for (int i = 0; i < 20 && bus.line_valid; i++) tick();
        check("offer_accepted", 64'(bus.line_valid), 64'd0);
    endtask

    task automatic exp_instr(input string tag, input int max_wait, input logic [31:0] instr,
                             input logic [31:0] pc_byte, input logic comp, input logic fault,
                             input logic illegal);
        bus.instr_ready_d0 = 1'b1;
        for (int i = 0; i < max_wait && !bus.instr_valid_d0; i++) tick();
        check({tag, "_valid"}, 64'(bus.instr_valid_d0), 64'd1);
        check({tag, "_instr"}, 64'(bus.instr_d0), 64'(instr));
        check({tag, "_pc"}, 64'(bus.pc_d0), 64'(pc_byte[31:1]));
        check({tag, "_flags"}, 64'({bus.comp_d0, bus.fault_d0, bus.illegal_d0}),
              64'({comp, fault, illegal}));
        tick();
    endtask

    task automatic flush_to(input logic [31:0] pc_byte);
        bus.flush_f  = 1'b1;
        bus.flush_pc = pc_byte[31:1];
        tick();
        bus.flush_f  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush_f        = 1'b0;
        bus.flush_pc       = '0;
        bus.line_valid     = 1'b0;
        bus.line_data      = '0;
        bus.line_pc        = '0;
        bus.line_err       = 1'b0;
        bus.instr_ready_d0 = 1'b0;

        repeat (3) tick();
        check("rst_valid", 64'(bus.instr_valid_d0), 64'd0);
        check("rst_instr", 64'(bus.instr_d0), 64'h13);
        check("rst_pc", 64'(bus.pc_d0), 64'd0);
        check("rst_flags", 64'({bus.comp_d0, bus.fault_d0, bus.illegal_d0}), 64'd0);
        check("rst_line_ready", 64'(bus.line_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Mixed 32/16/16 line at pc 0
        offer('{data: 64'h0001_0001_00A0_0093, pc: 31'h0, err: 1'b0});
        exp_instr("mix0", 5, 32'h00A0_0093, 32'h0, 1'b0, 1'b0, 1'b0);
        exp_instr("mix1", 0, 32'h1, 32'h4, 1'b1, 1'b0, 1'b0);
        exp_instr("mix2", 0, 32'h1, 32'h6, 1'b1, 1'b0, 1'b0);
        check("mix_drained", 64'(bus.instr_valid_d0), 64'd0);

        // Straddle from line 0x8 into line 0x10
        bus.instr_ready_d0 = 1'b0;
        offer('{data: 64'h0113_0001_0001_0001, pc: 31'h4, err: 1'b0});
        offer('{data: 64'h0001_0001_4501_0010, pc: 31'h8, err: 1'b0});
        exp_instr("str0", 5, 32'h1, 32'h8, 1'b1, 1'b0, 1'b0);
        exp_instr("str1", 0, 32'h1, 32'hA, 1'b1, 1'b0, 1'b0);
        exp_instr("str2", 0, 32'h1, 32'hC, 1'b1, 1'b0, 1'b0);
        exp_instr("str3", 0, 32'h0010_0113, 32'hE, 1'b0, 1'b0, 1'b0);
        exp_instr("str4", 0, 32'h4501, 32'h12, 1'b1, 1'b0, 1'b0);
        exp_instr("str5", 0, 32'h1, 32'h14, 1'b1, 1'b0, 1'b0);
        exp_instr("str6", 0, 32'h1, 32'h16, 1'b1, 1'b0, 1'b0);

        // Redirect to 0x1A; the line handshaking during the flush must be dropped
        bus.instr_ready_d0 = 1'b0;
        bus.line_valid = 1'b1;
        bus.line_pc    = 31'hC;
        bus.line_data  = 64'h1111_1111_1111_1111;
        bus.line_err   = 1'b0;
        flush_to(32'h1A);
        bus.line_valid = 1'b0;
        check("flush_valid", 64'(bus.instr_valid_d0), 64'd0);
        check("flush_line_ready", 64'(bus.line_ready), 64'd1);
        offer('{data: 64'h2222_2222_2222_2222, pc: 31'h10, err: 1'b0});
        offer('{data: 64'h0009_0006_0005_0000, pc: 31'hC, err: 1'b0});
        exp_instr("red0", 5, 32'h5, 32'h1A, 1'b1, 1'b0, 1'b0);
        exp_instr("red1", 0, 32'h6, 32'h1C, 1'b1, 1'b0, 1'b0);
        exp_instr("red2", 0, 32'h9, 32'h1E, 1'b1, 1'b0, 1'b0);

        // Good line 0x38 straddling into error line 0x40
        bus.instr_ready_d0 = 1'b0;
        flush_to(32'h38);
        offer('{data: 64'h0093_0001_0001_0001, pc: 31'h1C, err: 1'b0});
        offer('{data: 64'h0001_0001_0001_0000, pc: 31'h20, err: 1'b1});
        exp_instr("err0", 5, 32'h1, 32'h38, 1'b1, 1'b0, 1'b0);
        exp_instr("err1", 0, 32'h1, 32'h3A, 1'b1, 1'b0, 1'b0);
        exp_instr("err2", 0, 32'h1, 32'h3C, 1'b1, 1'b0, 1'b0);
        exp_instr("err3", 0, 32'h0000_0093, 32'h3E, 1'b0, 1'b1, 1'b0);
        exp_instr("err4", 0, 32'h1, 32'h42, 1'b1, 1'b1, 1'b0);
        exp_instr("err5", 0, 32'h1, 32'h44, 1'b1, 1'b1, 1'b0);
        exp_instr("err6", 0, 32'h1, 32'h46, 1'b1, 1'b1, 1'b0);

        // Backpressure: two lines fill the buffer, a third waits
        bus.instr_ready_d0 = 1'b0;
        offer('{data: 64'h0011_000D_0009_0005, pc: 31'h24, err: 1'b0});
        offer('{data: 64'h0019_0015_0000_001F, pc: 31'h28, err: 1'b0});
        check("bp_full", 64'(bus.line_ready), 64'd0);
        bus.line_valid = 1'b1;
        bus.line_pc    = 31'h2C;
        bus.line_data  = 64'h0029_0025_0021_001D;
        bus.line_err   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(bus.instr_valid_d0), 64'd1);
            check("bp_hold_instr", 64'(bus.instr_d0), 64'h5);
            check("bp_hold_pc", 64'(bus.pc_d0), 64'h24);
            check("bp_hold_line_ready", 64'(bus.line_ready), 64'd0);
        end
        exp_instr("bp0", 0, 32'h5, 32'h48, 1'b1, 1'b0, 1'b0);
        exp_instr("bp1", 0, 32'h9, 32'h4A, 1'b1, 1'b0, 1'b0);
        exp_instr("bp2", 0, 32'hD, 32'h4C, 1'b1, 1'b0, 1'b0);
        exp_instr("bp3", 0, 32'h11, 32'h4E, 1'b1, 1'b0, 1'b0);
        exp_instr("bp4", 0, 32'h0000_001F, 32'h50, 1'b0, 1'b0, 1'b1);
        exp_instr("bp5", 0, 32'h15, 32'h54, 1'b1, 1'b0, 1'b0);
        exp_instr("bp6", 0, 32'h19, 32'h56, 1'b1, 1'b0, 1'b0);
        exp_instr("bp7", 0, 32'h1D, 32'h58, 1'b1, 1'b0, 1'b0);
        exp_instr("bp8", 0, 32'h21, 32'h5A, 1'b1, 1'b0, 1'b0);
        exp_instr("bp9", 0, 32'h25, 32'h5C, 1'b1, 1'b0, 1'b0);
        exp_instr("bp10", 0, 32'h29, 32'h5E, 1'b1, 1'b0, 1'b0);
        check("bp_third_line_taken", 64'(bus.line_valid), 64'd0);
        check("bp_no_duplicate", 64'(bus.instr_valid_d0), 64'd0);

        // Asynchronous reset while an instruction is held
        bus.instr_ready_d0 = 1'b0;
        offer('{data: 64'h0001_0001_0001_0001, pc: 31'h30, err: 1'b0});
        tick();
        check("ar_pre_valid", 64'(bus.instr_valid_d0), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(bus.instr_valid_d0), 64'd0);
        check("ar_instr", 64'(bus.instr_d0), 64'h13);
        check("ar_pc", 64'(bus.pc_d0), 64'd0);
        check("ar_line_ready", 64'(bus.line_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
